sar_search: RTL

Successive-approximation search engine that drives the trial operand of an external magnitude comparator and consumes its gt/eq/lt flags. It recovers an unknown WIDTH-bit value `a`, presented only on the comparator's other input, MSB first, one bit per clock. It is the initiator side of the comparator interface: it generates the `b` operand and interprets the results that the comparator tree returns.

---
 rtl/sar_search.sv | 108 ++++++++++
 1 files changed

// File: rtl/sar_search.sv
// Successive-approximation search engine: drives the comparator b operand MSB first and
// rebuilds the unknown operand a from gt/eq/lt. Optional macro SAR_EARLY_EXIT_EN stops on a clean eq.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] cmp_b_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             onehot_d;
  logic             hit_d;
  logic             last_d;
  logic [WIDTH-1:0] trial_d;
  logic [WIDTH-1:0] next_b_d;

  // Bad flag combinations are treated as keep-bit, so only a clean lt clears the trial bit.
  always_comb begin
    onehot_d = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
               ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
               ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);
    trial_d = cmp_b_q;
    if (onehot_d && cmp_lt) trial_d[k_q] = 1'b0;
    next_b_d = trial_d;
    if (k_q != '0) next_b_d[k_q - 1'b1] = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
    hit_d = onehot_d && cmp_eq;
`else
    hit_d = 1'b0;
`endif
    last_d = (k_q == '0) || hit_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      cmp_b_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            cmp_b_q <= {1'b1, {(WIDTH-1){1'b0}}};
            k_q     <= KW'(WIDTH - 1);
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          err_q <= err_q | ~onehot_d;
          if (last_d) begin
            // On an early hit the untried low bits are already zero, so trial_d equals cmp_b.
            result_q <= trial_d;
            cmp_b_q  <= trial_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cmp_b_q <= next_b_d;
            k_q     <= k_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmp_b  = cmp_b_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
